// File: rtl/entry_pkg.sv
// Shared definitions for the front-panel value entry sequencer:
// state encoding, BCD limits and the per-state digit-enable pattern.
package entry_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned SEG_W = 4;

    localparam logic [NIB_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [SEG_W-1:0] SEG_IDLE = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D0   = 2'd1,
        D1   = 2'd2,
        D2   = 2'd3
    } state_t;

    // Digit under entry shows the blink phase, earlier digits stay lit, later ones dark.
    function automatic logic [SEG_W-1:0] seg_pattern(input state_t st, input logic ph);
        case (st)
            D0:      return {3'b000, ph};
            D1:      return {2'b00, ph, 1'b1};
            D2:      return {1'b0, ph, 2'b11};
            default: return SEG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Enter-key conditioning: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_enter
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_armed;
    logic             r_enter;
    logic [CNT_W-1:0] r_cnt;
    logic             w_settle;

    assign w_settle = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
    assign o_enter  = r_enter;

    // Presses only count once a released key has been seen after reset,
    // so a key held through reset cannot fire when reset lifts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b1;
            r_armed <= 1'b0;
            r_enter <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if ((r_sync2 == r_level) || w_settle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_settle) begin
                r_level <= r_sync2;
            end
            if (r_level && r_sync2) begin
                r_armed <= 1'b1;
            end
            r_enter <= w_settle && !r_sync2 && r_armed;
        end
    end

endmodule

// File: rtl/value_entry.sv
// Front-panel value entry: captures ones, tens, hundreds BCD nibbles on
// successive enter presses and strobes out the completed 12-bit value.
module value_entry
    import entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = 8,
    parameter int unsigned BLINK_BITS = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             KEY_N,
    input  logic [NIB_W-1:0] SW,
    output logic [1:0]       input_state,
    output logic [BCD_W-1:0] entry_bcd,
    output logic [BCD_W-1:0] value,
    output logic             value_valid,
    output logic             entry_err,
    output logic [SEG_W-1:0] seg_en
);

    logic                  w_enter;
    logic                  w_nib_ok;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [BCD_W-1:0]      r_entry;
    logic [BCD_W-1:0]      w_entry_nxt;
    logic [BCD_W-1:0]      r_value;
    logic [BCD_W-1:0]      w_value_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [BLINK_BITS-1:0] r_blink;
    logic [BLINK_BITS-1:0] w_blink_nxt;
    logic [SEG_W-1:0]      r_seg;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debounce (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_key_n (KEY_N),
        .o_enter (w_enter)
    );

    assign w_nib_ok    = (SW <= BCD_MAX);
    assign w_blink_nxt = r_blink + BLINK_BITS'(1);

    assign input_state = r_state;
    assign entry_bcd   = r_entry;
    assign value       = r_value;
    assign value_valid = r_valid;
    assign entry_err   = r_err;
    assign seg_en      = r_seg;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and capture values; a rejected nibble only raises the error flag.
    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_value_nxt = r_value;
        w_valid_nxt = 1'b0;
        w_err_nxt   = r_err;
        if (w_enter) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = D0;
                    w_entry_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
                D0: begin
                    if (w_nib_ok) begin
                        w_entry_nxt[3:0] = SW;
                        w_err_nxt        = 1'b0;
                        w_state_nxt      = D1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                D1: begin
                    if (w_nib_ok) begin
                        w_entry_nxt[7:4] = SW;
                        w_err_nxt        = 1'b0;
                        w_state_nxt      = D2;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                D2: begin
                    if (w_nib_ok) begin
                        w_entry_nxt[11:8] = SW;
                        w_value_nxt       = {SW, r_entry[7:0]};
                        w_valid_nxt       = 1'b1;
                        w_err_nxt         = 1'b0;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // seg_en is built from next-state values so it stays aligned with r_state.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_entry <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_blink <= '0;
            r_seg   <= SEG_IDLE;
        end else begin
            r_entry <= w_entry_nxt;
            r_value <= w_value_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_blink <= w_blink_nxt;
            r_seg   <= seg_pattern(w_state_nxt, w_blink_nxt[BLINK_BITS-1]);
        end
    end

endmodule

// File: tb/tb_value_entry.sv
// Self-checking bench for value_entry: a cycle-level behavioural model is
// compared every cycle, plus directed literal expectations.
module tb_value_entry;

    localparam int unsigned DB = 8;
    localparam int unsigned BB = 4;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        KEY_N    = 1'b1;
    logic [3:0]  SW       = 4'd0;
    logic [1:0]  input_state;
    logic [11:0] entry_bcd;
    logic [11:0] value;
    logic        value_valid;
    logic        entry_err;
    logic [3:0]  seg_en;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    value_entry #(
        .DEBOUNCE   (DB),
        .BLINK_BITS (BB)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .KEY_N       (KEY_N),
        .SW          (SW),
        .input_state (input_state),
        .entry_bcd   (entry_bcd),
        .value       (value),
        .value_valid (value_valid),
        .entry_err   (entry_err),
        .seg_en      (seg_en)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: key seen two cycles late, level flips after DB
    // consecutive disagreeing cycles, entry digits indexed by state.
    int          m_state;
    logic [11:0] m_entry;
    logic [11:0] m_value;
    bit          m_valid;
    bit          m_err;
    bit          m_enter;
    bit          m_d1;
    bit          m_d2;
    bit          m_level;
    bit          m_armed;
    bit          m_live = 1'b0;
    int          m_run;
    int          m_tick;
    int          m_dg;
    bit          m_seen;
    bit          m_old_level;

    always @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            m_state = 0; m_entry = '0; m_value = '0; m_valid = 0; m_err = 0;
            m_enter = 0; m_d1 = 0; m_d2 = 0; m_level = 1; m_armed = 0;
            m_run = 0; m_tick = 0; m_live = 1;
        end else begin
            m_valid = 0;
            if (m_enter) begin
                if (m_state == 0) begin
                    m_state = 1; m_entry = '0; m_err = 0;
                end else if (SW > 4'd9) begin
                    m_err = 1;
                end else begin
                    m_dg = m_state - 1;
                    m_entry[m_dg*4 +: 4] = SW;
                    m_err = 0;
                    if (m_state == 3) begin
                        m_value = m_entry; m_valid = 1; m_state = 0;
                    end else begin
                        m_state = m_state + 1;
                    end
                end
            end
            m_seen = m_d2;
            m_old_level = m_level;
            m_enter = 0;
            if (m_seen != m_level) m_run = m_run + 1;
            else m_run = 0;
            if (m_run == int'(DB)) begin
                m_level = m_seen;
                m_run = 0;
                if (!m_seen && m_armed) m_enter = 1;
            end
            if (m_old_level && m_seen) m_armed = 1;
            m_d2 = m_d1;
            m_d1 = KEY_N;
            m_tick = m_tick + 1;
        end
    end

    function automatic logic [3:0] exp_seg(input int st, input bit ph);
        logic [3:0] lit;
        logic [3:0] cur;
        if (st == 0) return 4'b0111;
        lit = 4'((1 << (st - 1)) - 1);
        cur = 4'(int'(ph) << (st - 1));
        return lit | cur;
    endfunction

    always @(negedge CLOCK_50) begin
        if (m_live) begin
            chk("state",       32'(input_state), 32'(m_state));
            chk("entry_bcd",   32'(entry_bcd),   32'(m_entry));
            chk("value",       32'(value),       32'(m_value));
            chk("value_valid", 32'(value_valid), 32'(m_valid));
            chk("entry_err",   32'(entry_err),   32'(m_err));
            chk("seg_en",      32'(seg_en),      32'(exp_seg(m_state, (m_tick % 16) >= 8)));
            if (value_valid) strobes++;
        end
    end

    task automatic press(input logic [3:0] sw);
        @(negedge CLOCK_50);
        SW    = sw;
        KEY_N = 1'b0;
        repeat (DB + 6) @(negedge CLOCK_50);
        KEY_N = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int  tog;
    bit  b0_ok;
    bit  hi_ok;
    logic prev_b1;

    initial begin
        // Reset values
        repeat (3) @(negedge CLOCK_50);
        chk("rst_state", 32'(input_state), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_seg",   32'(seg_en), 32'h7);
        #2 RESET = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Full entry of 123
        press(4'd0); chk("full_s1", 32'(input_state), 32'd1);
        press(4'd3); chk("full_s2", 32'(input_state), 32'd2);
        chk("full_ones", 32'(entry_bcd[3:0]), 32'd3);
        press(4'd2); chk("full_s3", 32'(input_state), 32'd3);
        press(4'd1); chk("full_s0", 32'(input_state), 32'd0);
        chk("full_value", 32'(value), 32'h123);
        chk("full_strobes", 32'(strobes), 32'd1);

        // Back-to-back 875 then 440
        press(4'd0); press(4'd5); press(4'd7); press(4'd8);
        chk("b2b_875", 32'(value), 32'h875);
        press(4'd0); press(4'd0); press(4'd4); press(4'd4);
        chk("b2b_440", 32'(value), 32'h440);
        chk("b2b_strobes", 32'(strobes), 32'd3);

        // Invalid nibble rejected, then accepted
        press(4'd0);
        press(4'hA);
        chk("inv_state", 32'(input_state), 32'd1);
        chk("inv_err",   32'(entry_err), 32'd1);
        press(4'd5);
        chk("ok_state", 32'(input_state), 32'd2);
        chk("ok_err",   32'(entry_err), 32'd0);
        chk("ok_ones",  32'(entry_bcd[3:0]), 32'd5);

        // Blink in D1
        tog = 0; b0_ok = 1; hi_ok = 1;
        @(negedge CLOCK_50);
        prev_b1 = seg_en[1];
        repeat (32) begin
            @(negedge CLOCK_50);
            if (seg_en[1] !== prev_b1) tog++;
            prev_b1 = seg_en[1];
            if (seg_en[0] !== 1'b1) b0_ok = 0;
            if (seg_en[3:2] !== 2'b00) hi_ok = 0;
        end
        chk("blink_toggles", 32'(tog), 32'd4);
        chk("blink_bit0",    32'(b0_ok), 32'd1);
        chk("blink_hi",      32'(hi_ok), 32'd1);

        // Reset mid-D1
        @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        @(negedge CLOCK_50);
        chk("mid_rst_state", 32'(input_state), 32'd0);
        chk("mid_rst_entry", 32'(entry_bcd), 32'd0);
        chk("mid_rst_value", 32'(value), 32'd0);
        chk("mid_rst_err",   32'(entry_err), 32'd0);
        chk("mid_rst_seg",   32'(seg_en), 32'h7);
        #2 RESET = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Short glitches ignored
        repeat (3) begin
            @(negedge CLOCK_50);
            KEY_N = 1'b0;
            repeat (DB - 2) @(negedge CLOCK_50);
            KEY_N = 1'b1;
            repeat (6) @(negedge CLOCK_50);
        end
        repeat (DB) @(negedge CLOCK_50);
        chk("bounce_state", 32'(input_state), 32'd0);

        // Clean press latency
        @(negedge CLOCK_50);
        KEY_N = 1'b0;
        repeat (DB + 2) @(negedge CLOCK_50);
        chk("lat_before", 32'(input_state), 32'd0);
        @(negedge CLOCK_50);
        chk("lat_after", 32'(input_state), 32'd1);
        KEY_N = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);

        // Key held through reset must not fire
        @(negedge CLOCK_50);
        KEY_N = 1'b0;
        #2 RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        #2 RESET = 1'b0;
        repeat (3 * DB + 10) @(negedge CLOCK_50);
        chk("held_state", 32'(input_state), 32'd0);
        KEY_N = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);
        press(4'd0);
        chk("held_then_press", 32'(input_state), 32'd1);
        chk("final_strobes", 32'(strobes), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
